// File: rtl/rs_pkg.sv
// Shared constants for the reservation-station banks: reserved tags, unit tag bases, opcodes.
package rs_pkg;

    localparam int unsigned DEF_TAG_W = 8;
    localparam int unsigned DEF_OP_W  = 3;

    localparam logic [DEF_TAG_W-1:0] TAG_NONE     = 8'b0111_1111;
    localparam logic [DEF_TAG_W-1:0] TAG_BASE_ADD = 8'b0010_0000;
    localparam logic [DEF_TAG_W-1:0] TAG_BASE_MUL = 8'b0100_0000;
    localparam logic [DEF_TAG_W-1:0] TAG_BASE_LW  = 8'b1000_0000;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_LW   = 3'b000,
        OP_SW   = 3'b001,
        OP_ADD  = 3'b010,
        OP_MUL  = 3'b011,
        OP_MV   = 3'b100,
        OP_HALT = 3'b101
    } rs_op_e;

endpackage

// File: rtl/rs_age_select.sv
// Age matrix over the bank's entries and one-hot pick of the oldest ready candidate.
module rs_age_select
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [DEPTH-1:0] i_alloc,
    input  logic [DEPTH-1:0] i_valid,
    input  logic [DEPTH-1:0] i_cand,
    output logic [DEPTH-1:0] o_pick,
    output logic             o_any
);

    // r_older[i][j]: entry i was allocated before entry j
    logic [DEPTH-1:0] r_older [DEPTH];
    logic [DEPTH-1:0] w_blocked;

    // A new entry is younger than everything currently valid; its own row is cleared
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (i_alloc[k]) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_older[k][i] <= 1'b0;
                        if (i != k) begin
                            r_older[i][k] <= i_valid[i];
                        end
                    end
                end
            end
        end
    end

    // A candidate is blocked if any other candidate is older than it
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && i_cand[j] && r_older[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
    end

    assign o_pick = i_cand & ~w_blocked;
    assign o_any  = |i_cand;

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: holds waiting instructions, snoops the CDBs for missing
// operands and dispatches the oldest fully-ready entry through a valid/ready handshake.
module rs_bank
    import rs_pkg::*;
#(
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      WORD_SIZE = 32,
    parameter int unsigned      TAG_W     = 8,
    parameter int unsigned      OP_W      = 3,
    parameter int unsigned      NCDB      = 1,
    parameter logic [TAG_W-1:0] TAG_BASE  = TAG_W'(TAG_BASE_ADD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [OP_W-1:0]           issue_op,
    input  logic [TAG_W-1:0]          issue_tag_a,
    input  logic [TAG_W-1:0]          issue_tag_b,
    input  logic [WORD_SIZE-1:0]      issue_val_a,
    input  logic [WORD_SIZE-1:0]      issue_val_b,
    output logic [TAG_W-1:0]          issue_alloc_tag,
    input  logic [NCDB-1:0]           cdb_valid,
    input  logic [NCDB*TAG_W-1:0]     cdb_tag,
    input  logic [NCDB*WORD_SIZE-1:0] cdb_data,
    output logic                      disp_valid,
    input  logic                      disp_ready,
    output logic [OP_W-1:0]           disp_op,
    output logic [WORD_SIZE-1:0]      disp_a,
    output logic [WORD_SIZE-1:0]      disp_b,
    output logic [TAG_W-1:0]          disp_tag,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TW1   = TAG_W + 1;

    localparam logic [TAG_W-1:0] L_TAG_NONE = TAG_W'(TAG_NONE);
    localparam logic [TW1-1:0]   TAG_FIRST  = TW1'(TAG_BASE);
    localparam logic [TW1-1:0]   TAG_LAST   = TW1'(TAG_BASE) + TW1'(DEPTH - 1);
    localparam logic [TW1-1:0]   TAG_NONE_X = TW1'(L_TAG_NONE);

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
        $error("rs_bank: DEPTH must be in 2..32");
    end
    if (NCDB < 1 || NCDB > 4) begin : g_bad_ncdb
        $error("rs_bank: NCDB must be in 1..4");
    end
    if (TAG_LAST[TAG_W] || (TAG_NONE_X >= TAG_FIRST && TAG_NONE_X <= TAG_LAST)) begin : g_bad_tags
        $error("rs_bank: entry tag range wraps or reaches TAG_NONE");
    end

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_rdy_a;
    logic [DEPTH-1:0]     r_rdy_b;
    logic [OP_W-1:0]      r_op    [DEPTH];
    logic [TAG_W-1:0]     r_tag_a [DEPTH];
    logic [TAG_W-1:0]     r_tag_b [DEPTH];
    logic [WORD_SIZE-1:0] r_val_a [DEPTH];
    logic [WORD_SIZE-1:0] r_val_b [DEPTH];
    logic [CNT_W-1:0]     r_count;

    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_has_free;
    logic                 w_issue_fire;
    logic                 w_disp_fire;
    logic [DEPTH-1:0]     w_alloc_oh;
    logic [DEPTH-1:0]     w_cand;
    logic [DEPTH-1:0]     w_pick;
    logic [DEPTH-1:0]     w_disp_oh;
    logic                 w_any;
    logic [WORD_SIZE:0]   w_cap_a;
    logic [WORD_SIZE:0]   w_cap_b;
    logic                 w_new_rdy_a;
    logic                 w_new_rdy_b;
    logic [WORD_SIZE-1:0] w_new_val_a;
    logic [WORD_SIZE-1:0] w_new_val_b;
    logic [WORD_SIZE:0]   w_snp_a [DEPTH];
    logic [WORD_SIZE:0]   w_snp_b [DEPTH];

    // Returns {hit, data}; the lowest matching port wins
    function automatic logic [WORD_SIZE:0] cdb_match(
        input logic [TAG_W-1:0]          tag,
        input logic [NCDB-1:0]           v,
        input logic [NCDB*TAG_W-1:0]     tags,
        input logic [NCDB*WORD_SIZE-1:0] data
    );
        logic [WORD_SIZE:0] res;
        res = '0;
        for (int p = int'(NCDB) - 1; p >= 0; p--) begin
            if (v[p] && tags[p*TAG_W +: TAG_W] == tag) begin
                res = {1'b1, data[p*WORD_SIZE +: WORD_SIZE]};
            end
        end
        return res;
    endfunction

    // Lowest-index free entry
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_has_free      = ~&r_valid;
    assign issue_ready     = w_has_free && !flush;
    assign issue_alloc_tag = TAG_BASE + TAG_W'(w_free_idx);
    assign w_issue_fire    = issue_valid && issue_ready;
    assign w_alloc_oh      = w_issue_fire ? (DEPTH'(1) << w_free_idx) : '0;

    // Operand capture at issue: immediate value, same-cycle CDB hit, or wait on tag
    assign w_cap_a     = cdb_match(issue_tag_a, cdb_valid, cdb_tag, cdb_data);
    assign w_cap_b     = cdb_match(issue_tag_b, cdb_valid, cdb_tag, cdb_data);
    assign w_new_rdy_a = (issue_tag_a == L_TAG_NONE) || w_cap_a[WORD_SIZE];
    assign w_new_rdy_b = (issue_tag_b == L_TAG_NONE) || w_cap_b[WORD_SIZE];
    assign w_new_val_a = (issue_tag_a == L_TAG_NONE) ? issue_val_a : w_cap_a[WORD_SIZE-1:0];
    assign w_new_val_b = (issue_tag_b == L_TAG_NONE) ? issue_val_b : w_cap_b[WORD_SIZE-1:0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_snp_a[i] = cdb_match(r_tag_a[i], cdb_valid, cdb_tag, cdb_data);
            w_snp_b[i] = cdb_match(r_tag_b[i], cdb_valid, cdb_tag, cdb_data);
        end
    end

    assign w_cand = r_valid & r_rdy_a & r_rdy_b;

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_alloc (w_alloc_oh),
        .i_valid (r_valid),
        .i_cand  (w_cand),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    assign disp_valid  = w_any;
    assign w_disp_fire = w_any && disp_ready;
    assign w_disp_oh   = w_disp_fire ? w_pick : '0;

    // Dispatch mux from registered entry state only; zero when nothing is selected
    always_comb begin
        disp_op  = '0;
        disp_a   = '0;
        disp_b   = '0;
        disp_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pick[i]) begin
                disp_op  = r_op[i];
                disp_a   = r_val_a[i];
                disp_b   = r_val_b[i];
                disp_tag = TAG_BASE + TAG_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_valid <= '0;
            r_rdy_a <= '0;
            r_rdy_b <= '0;
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_disp_fire);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_op[i]    <= issue_op;
                    r_tag_a[i] <= issue_tag_a;
                    r_tag_b[i] <= issue_tag_b;
                    r_rdy_a[i] <= w_new_rdy_a;
                    r_rdy_b[i] <= w_new_rdy_b;
                    r_val_a[i] <= w_new_val_a;
                    r_val_b[i] <= w_new_val_b;
                end else if (r_valid[i]) begin
                    if (w_disp_oh[i]) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (!r_rdy_a[i] && w_snp_a[i][WORD_SIZE]) begin
                        r_rdy_a[i] <= 1'b1;
                        r_val_a[i] <= w_snp_a[i][WORD_SIZE-1:0];
                    end
                    if (!r_rdy_b[i] && w_snp_b[i][WORD_SIZE]) begin
                        r_rdy_b[i] <= 1'b1;
                        r_val_b[i] <= w_snp_b[i][WORD_SIZE-1:0];
                    end
                end
            end
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);

endmodule

// File: tb/tb_rs_bank.sv
// Scoreboard bench for rs_bank: directed scenarios then random traffic against a
// sequence-number reference model; a monitor checks every dispatch and allocation.
module tb_rs_bank;
    import rs_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCDB  = 2;
    localparam int unsigned WS    = 32;
    localparam int unsigned TW    = 8;
    localparam int unsigned OW    = 3;
    localparam logic [7:0]  TNONE = TAG_NONE;
    localparam logic [7:0]  TBASE = 8'h20;

    logic                clk = 1'b0;
    logic                rst_n, flush, issue_valid, issue_ready;
    logic [OW-1:0]       issue_op;
    logic [TW-1:0]       issue_tag_a, issue_tag_b, issue_alloc_tag;
    logic [WS-1:0]       issue_val_a, issue_val_b;
    logic [NCDB-1:0]     cdb_valid;
    logic [NCDB*TW-1:0]  cdb_tag;
    logic [NCDB*WS-1:0]  cdb_data;
    logic                disp_valid, disp_ready, empty;
    logic [OW-1:0]       disp_op;
    logic [WS-1:0]       disp_a, disp_b;
    logic [TW-1:0]       disp_tag;
    logic [2:0]          count;

    always #5 clk = ~clk;

    rs_bank #(
        .DEPTH(DEPTH), .WORD_SIZE(WS), .TAG_W(TW), .OP_W(OW), .NCDB(NCDB), .TAG_BASE(TBASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_tag_a(issue_tag_a), .issue_tag_b(issue_tag_b),
        .issue_val_a(issue_val_a), .issue_val_b(issue_val_b),
        .issue_alloc_tag(issue_alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag),
        .count(count), .empty(empty)
    );

    typedef struct packed {
        logic [OW-1:0] op;
        logic [WS-1:0] a;
        logic [WS-1:0] b;
        logic [TW-1:0] tag;
    } disp_rec_t;

    disp_rec_t  q_disp[$];
    logic [7:0] q_alloc[$];
    int total = 0;
    int bad   = 0;

    // Reference model: entries ordered by allocation sequence number
    logic          m_valid [DEPTH];
    logic          m_ra    [DEPTH];
    logic          m_rb    [DEPTH];
    logic [OW-1:0] m_op    [DEPTH];
    logic [7:0]    m_ta    [DEPTH];
    logic [7:0]    m_tb    [DEPTH];
    logic [WS-1:0] m_va    [DEPTH];
    logic [WS-1:0] m_vb    [DEPTH];
    int            m_seq   [DEPTH];
    int            seq_ctr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mlook(input logic [7:0] t, output logic hit, output logic [WS-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int p = 0; p < NCDB; p++) begin
            if (!hit && cdb_valid[p] && cdb_tag[p*TW +: TW] == t) begin
                hit = 1'b1;
                d   = cdb_data[p*WS +: WS];
            end
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ra[i]    = 1'b0;
            m_rb[i]    = 1'b0;
        end
    endtask

    task automatic model_eval();
        int         nval, free_idx, pick;
        logic       exp_ready, exp_dv, hit;
        logic [WS-1:0] d;
        disp_rec_t  rec;
        if (!rst_n) begin
            model_clear();
            return;
        end
        nval = 0;
        free_idx = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) nval++;
            else if (free_idx < 0) free_idx = i;
        end
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_ra[i] && m_rb[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
        end
        exp_ready = (free_idx >= 0) && !flush;
        exp_dv    = (pick >= 0);
        check("issue_ready", 64'(issue_ready), 64'(exp_ready));
        check("disp_valid", 64'(disp_valid), 64'(exp_dv));
        check("count", 64'(count), 64'(nval));
        check("empty", 64'(empty), 64'(nval == 0));
        if (issue_valid && exp_ready) q_alloc.push_back(TBASE + 8'(free_idx));
        if (exp_dv && disp_ready) begin
            rec.op  = m_op[pick];
            rec.a   = m_va[pick];
            rec.b   = m_vb[pick];
            rec.tag = TBASE + 8'(pick);
            q_disp.push_back(rec);
        end
        if (flush) begin
            model_clear();
        end else begin
            if (exp_dv && disp_ready) m_valid[pick] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && !m_ra[i]) begin
                    mlook(m_ta[i], hit, d);
                    if (hit) begin m_ra[i] = 1'b1; m_va[i] = d; end
                end
                if (m_valid[i] && !m_rb[i]) begin
                    mlook(m_tb[i], hit, d);
                    if (hit) begin m_rb[i] = 1'b1; m_vb[i] = d; end
                end
            end
            if (issue_valid && exp_ready) begin
                m_valid[free_idx] = 1'b1;
                m_op[free_idx]    = issue_op;
                m_ta[free_idx]    = issue_tag_a;
                m_tb[free_idx]    = issue_tag_b;
                m_seq[free_idx]   = seq_ctr++;
                if (issue_tag_a == TNONE) begin
                    m_ra[free_idx] = 1'b1; m_va[free_idx] = issue_val_a;
                end else begin
                    mlook(issue_tag_a, hit, d);
                    m_ra[free_idx] = hit; m_va[free_idx] = d;
                end
                if (issue_tag_b == TNONE) begin
                    m_rb[free_idx] = 1'b1; m_vb[free_idx] = issue_val_b;
                end else begin
                    mlook(issue_tag_b, hit, d);
                    m_rb[free_idx] = hit; m_vb[free_idx] = d;
                end
            end
        end
    endtask

    // Monitor: compares every handshake the DUT performs against the scoreboard queues
    always @(negedge clk) begin
        disp_rec_t e;
        #3;
        if (rst_n === 1'b1) begin
            if (issue_valid && issue_ready) begin
                if (q_alloc.size() == 0) check("alloc_unexpected", 64'(issue_alloc_tag), 64'hFFFF);
                else check("alloc_tag", 64'(issue_alloc_tag), 64'(q_alloc.pop_front()));
            end
            if (disp_valid && disp_ready) begin
                if (q_disp.size() == 0) begin
                    check("disp_unexpected", 64'(disp_tag), 64'hFFFF);
                end else begin
                    e = q_disp.pop_front();
                    check("disp_tag", 64'(disp_tag), 64'(e.tag));
                    check("disp_op", 64'(disp_op), 64'(e.op));
                    check("disp_a", 64'(disp_a), 64'(e.a));
                    check("disp_b", 64'(disp_b), 64'(e.b));
                end
            end
        end
    end

    task automatic cyc();
        #2;
        model_eval();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_tag_a = TNONE; issue_tag_b = TNONE; issue_val_a = '0; issue_val_b = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; disp_ready = 1'b0;
    endtask

    task automatic iss(input logic [2:0] op, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [WS-1:0] va, input logic [WS-1:0] vb);
        issue_valid = 1'b1; issue_op = op;
        issue_tag_a = ta; issue_tag_b = tb; issue_val_a = va; issue_val_b = vb;
    endtask

    function automatic logic [7:0] rtag();
        int r;
        r = int'($urandom_range(0, 5));
        return (r < 2) ? TNONE : 8'h40 + 8'(r - 2);
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Reset/ready: immediate operands dispatch the next cycle
        iss(OP_ADD, TNONE, TNONE, 32'd5, 32'd7);
        cyc();
        check("t1_dv", 64'(disp_valid), 64'd1);
        check("t1_a", 64'(disp_a), 64'd5);
        check("t1_b", 64'(disp_b), 64'd7);
        check("t1_tag", 64'(disp_tag), 64'h20);
        idle(); disp_ready = 1'b1;
        cyc();
        check("t1_count", 64'(count), 64'd0);

        // CDB wakeup
        idle(); iss(OP_MUL, 8'h41, TNONE, 32'd0, 32'd3);
        cyc();
        check("t2_wait", 64'(disp_valid), 64'd0);
        idle(); cdb_valid = 2'b01; cdb_tag = {8'h00, 8'h41}; cdb_data = {32'd0, 32'd100};
        cyc();
        check("t2_dv", 64'(disp_valid), 64'd1);
        check("t2_a", 64'(disp_a), 64'd100);
        check("t2_b", 64'(disp_b), 64'd3);
        idle(); disp_ready = 1'b1;
        cyc();

        // Same-cycle capture at issue, on the second CDB port
        idle(); iss(OP_LW, TNONE, 8'h82, 32'd9, 32'd0);
        cdb_valid = 2'b10; cdb_tag = {8'h82, 8'h00}; cdb_data = {32'hDEAD, 32'd0};
        cyc();
        check("t3_dv", 64'(disp_valid), 64'd1);
        check("t3_b", 64'(disp_b), 64'hDEAD);
        idle(); disp_ready = 1'b1;
        cyc();

        // Oldest-first among ready entries while held
        for (int i = 0; i < 4; i++) begin
            idle(); iss(OP_ADD, 8'h50 + 8'(i), TNONE, 32'd0, 32'(i));
            cyc();
        end
        idle(); cdb_valid = 2'b01; cdb_tag = {8'h00, 8'h53}; cdb_data = {32'd0, 32'h333};
        cyc();
        check("t4_first", 64'(disp_tag), 64'h23);
        idle(); cdb_valid = 2'b01; cdb_tag = {8'h00, 8'h51}; cdb_data = {32'd0, 32'h111};
        cyc();
        idle(); cyc();
        check("t4_older", 64'(disp_tag), 64'h21);
        disp_ready = 1'b1;
        cyc();
        check("t4_next", 64'(disp_tag), 64'h23);
        idle(); disp_ready = 1'b1;
        cdb_valid = 2'b11; cdb_tag = {8'h52, 8'h50}; cdb_data = {32'h222, 32'h0AA};
        cyc();
        idle(); disp_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Full and back-pressure
        for (int i = 0; i < 4; i++) begin
            idle(); iss(OP_MV, TNONE, TNONE, 32'(10 + i), 32'(20 + i));
            cyc();
        end
        check("t5_full", 64'(issue_ready), 64'd0);
        iss(OP_SW, TNONE, TNONE, 32'd77, 32'd88); disp_ready = 1'b1;
        cyc();
        check("t5_free", 64'(issue_ready), 64'd1);
        disp_ready = 1'b0;
        cyc();
        check("t5_refill", 64'(count), 64'd4);
        idle(); disp_ready = 1'b1;
        cyc();

        // Flush mid-operation with an issue and a dispatch in the same cycle
        check("t6_pre", 64'(count), 64'd3);
        idle(); flush = 1'b1; disp_ready = 1'b1; iss(OP_HALT, TNONE, TNONE, 32'd1, 32'd2);
        cyc();
        check("t6_count", 64'(count), 64'd0);
        check("t6_dv", 64'(disp_valid), 64'd0);
        idle();
        cyc();
        check("t6_ready", 64'(issue_ready), 64'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n       = (n == 1500) ? 1'b0 : 1'b1;
            flush       = ($urandom_range(0, 49) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_op    = 3'($urandom_range(0, 5));
            issue_tag_a = rtag();
            issue_tag_b = rtag();
            issue_val_a = $urandom;
            issue_val_b = $urandom;
            for (int p = 0; p < NCDB; p++) begin
                cdb_valid[p]          = ($urandom_range(0, 2) == 0);
                cdb_tag[p*TW +: TW]   = 8'h40 + 8'($urandom_range(0, 3));
                cdb_data[p*WS +: WS]  = $urandom;
            end
            disp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        idle(); rst_n = 1'b1;
        cyc();

        check("disp_q_left", 64'(q_disp.size()), 64'd0);
        check("alloc_q_left", 64'(q_alloc.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
